// File: rtl/bypass_ctrl_pkg.sv
// bypass_ctrl_pkg
// Shared definitions for the operand bypass / load-use stall controller.
//   SEL_*          forwarding select encodings driven onto rs_sel / rt_sel
//   LAT_*          result latency codes: the stage whose end makes a result usable
//   shadow_entry_t one shadow-pipeline slot {valid, addr, lat}
//   norm_lat()     folds the unused latency code 3 onto LAT_MEM2
// Optional feature macro used by the top level: BYPASS_STALL_CNT_EN.

package bypass_ctrl_pkg;

  localparam logic [1:0] SEL_GPR  = 2'b00;
  localparam logic [1:0] SEL_EX   = 2'b01;
  localparam logic [1:0] SEL_MEM1 = 2'b10;
  localparam logic [1:0] SEL_MEM2 = 2'b11;

  localparam logic [1:0] LAT_EX   = 2'd0;
  localparam logic [1:0] LAT_MEM1 = 2'd1;
  localparam logic [1:0] LAT_MEM2 = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic [1:0] lat;
  } shadow_entry_t;

  // Latency code 3 has no stage of its own; it behaves like a load.
  function automatic logic [1:0] norm_lat(input logic [1:0] lat);
    return (lat == 2'd3) ? LAT_MEM2 : lat;
  endfunction

endpackage

// File: rtl/bypass_match.sv
// bypass_match
// Resolves one source operand against the three shadow-pipeline entries.
// Ports:
//   ex_e, mem1_e, mem2_e  shadow entries, youngest (EX) to oldest (MEM2)
//   src                   source register number read in ID
//   rd                    1 when the ID instruction really reads src
//   sel                   forwarding select (SEL_GPR/EX/MEM1/MEM2)
//   not_ready             youngest matching producer has not finished yet

import bypass_ctrl_pkg::*;

module bypass_match (
  input  shadow_entry_t ex_e,
  input  shadow_entry_t mem1_e,
  input  shadow_entry_t mem2_e,
  input  logic [4:0]    src,
  input  logic          rd,
  output logic [1:0]    sel,
  output logic          not_ready
);

  logic src_live;
  logic hit_ex;
  logic hit_mem1;
  logic hit_mem2;

  // $0 is hardwired to zero, so a read of it never needs a forwarded value.
  assign src_live = rd && (src != 5'd0);
  assign hit_ex   = src_live && ex_e.valid   && (ex_e.addr   == src);
  assign hit_mem1 = src_live && mem1_e.valid && (mem1_e.addr == src);
  assign hit_mem2 = src_live && mem2_e.valid && (mem2_e.addr == src);

  // Only the youngest producer counts: an older write to the same register
  // is stale even if it is ready, so a not-ready young hit must stall rather
  // than fall through to an older stage.
  always_comb begin
    sel       = SEL_GPR;
    not_ready = 1'b0;
    if (hit_ex) begin
      if (ex_e.lat <= LAT_EX) sel = SEL_EX;
      else                    not_ready = 1'b1;
    end else if (hit_mem1) begin
      if (mem1_e.lat <= LAT_MEM1) sel = SEL_MEM1;
      else                        not_ready = 1'b1;
    end else if (hit_mem2) begin
      if (mem2_e.lat <= LAT_MEM2) sel = SEL_MEM2;
      else                        not_ready = 1'b1;
    end
  end

endmodule

// File: rtl/bypass_ctrl.sv
// bypass_ctrl
// Operand bypass selection and load-use interlock for a 5-stage-plus pipeline
// with results becoming available at the end of EX, MEM1 or MEM2.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   id_rs, id_rt             source registers of the ID instruction
//   id_rs_rd, id_rt_rd       ID instruction actually reads rs / rt
//   id_wr_en, id_wr_addr     destination write enable / address in ID
//   id_wr_lat                result latency code (0=EX, 1=MEM1, 2/3=MEM2)
//   hold                     global pipeline freeze
//   flush                    exception/eret flush of all younger stages
//   rs_sel, rt_sel           forwarding selects (00 GPR, 01 EX, 10 MEM1, 11 MEM2)
//   stall_id                 freeze PC/IF/ID and inject a bubble into EX
//   stall_cnt                (only with BYPASS_STALL_CNT_EN) count of stall cycles

import bypass_ctrl_pkg::*;

module bypass_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_rd,
  input  logic        id_rt_rd,
  input  logic        id_wr_en,
  input  logic [4:0]  id_wr_addr,
  input  logic [1:0]  id_wr_lat,
  input  logic        hold,
  input  logic        flush,
  output logic [1:0]  rs_sel,
  output logic [1:0]  rt_sel,
  output logic        stall_id
`ifdef BYPASS_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  shadow_entry_t ex_q;
  shadow_entry_t mem1_q;
  shadow_entry_t mem2_q;
  shadow_entry_t ex_next;

  logic [1:0] rs_sel_raw;
  logic [1:0] rt_sel_raw;
  logic       rs_not_ready;
  logic       rt_not_ready;

  bypass_match u_match_rs (
    .ex_e      (ex_q),
    .mem1_e    (mem1_q),
    .mem2_e    (mem2_q),
    .src       (id_rs),
    .rd        (id_rs_rd),
    .sel       (rs_sel_raw),
    .not_ready (rs_not_ready)
  );

  bypass_match u_match_rt (
    .ex_e      (ex_q),
    .mem1_e    (mem1_q),
    .mem2_e    (mem2_q),
    .src       (id_rt),
    .rd        (id_rt_rd),
    .sel       (rt_sel_raw),
    .not_ready (rt_not_ready)
  );

  // A flushed ID instruction is discarded anyway, so it must never stall;
  // reset masks everything because the entries are only cleared at the edge.
  assign stall_id = rst_n & ~flush & (rs_not_ready | rt_not_ready);
  assign rs_sel   = rst_n ? rs_sel_raw : SEL_GPR;
  assign rt_sel   = rst_n ? rt_sel_raw : SEL_GPR;

  // A stalled instruction stays in ID, so what enters EX is a bubble.
  always_comb begin
    ex_next.valid = id_wr_en & ~stall_id;
    ex_next.addr  = id_wr_addr;
    ex_next.lat   = norm_lat(id_wr_lat);
  end

  // Shadow pipeline: reset beats flush, flush beats hold. A flush only
  // drops valid bits; stale addr/lat left behind can never match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q   <= '0;
      mem1_q <= '0;
      mem2_q <= '0;
    end else if (flush) begin
      ex_q.valid   <= 1'b0;
      mem1_q.valid <= 1'b0;
      mem2_q.valid <= 1'b0;
    end else if (!hold) begin
      mem2_q <= mem1_q;
      mem1_q <= ex_q;
      ex_q   <= ex_next;
    end
  end

`ifdef BYPASS_STALL_CNT_EN
  // Cycles frozen by hold are not charged to the interlock; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n)              stall_cnt <= 32'd0;
    else if (stall_id && !hold) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_bypass_ctrl.sv
// tb_bypass_ctrl
// Scoreboard bench for bypass_ctrl. The driver applies one ID instruction per
// cycle, predicts the outputs from a list of in-flight writes tagged with their
// age in cycles since entering EX, and queues the prediction; a monitor pops
// and compares each cycle. Directed sequences for the classic hazards are
// followed by randomized traffic. Optional macro: BYPASS_STALL_CNT_EN.

module tb_bypass_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, id_wr_addr;
  logic        id_rs_rd, id_rt_rd, id_wr_en;
  logic [1:0]  id_wr_lat;
  logic        hold, flush;
  logic [1:0]  rs_sel, rt_sel;
  logic        stall_id;
`ifdef BYPASS_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  bypass_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_rd   (id_rs_rd),
    .id_rt_rd   (id_rt_rd),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_wr_lat  (id_wr_lat),
    .hold       (hold),
    .flush      (flush),
    .rs_sel     (rs_sel),
    .rt_sel     (rt_sel),
    .stall_id   (stall_id)
`ifdef BYPASS_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  rs_sel;
    logic [1:0]  rt_sel;
    logic        stall;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic [4:0] addr;
    int         lat;
    int         age;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         inflight[$];
  int unsigned model_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic        obs_stall;
  logic [1:0]  obs_rs;

  // The youngest in-flight write to src decides; it is usable once its age
  // has reached its latency, and the select names the stage it now sits in.
  function automatic void lookup(input logic [4:0] src, input logic rd,
                                 output logic [1:0] sel, output logic nr);
    sel = 2'b00;
    nr  = 1'b0;
    if (rd && src != 5'd0) begin
      for (int i = 0; i < inflight.size(); i++) begin
        if (inflight[i].addr == src) begin
          if (inflight[i].lat <= inflight[i].age) sel = 2'(inflight[i].age + 1);
          else                                     nr  = 1'b1;
          break;
        end
      end
    end
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic rs_rd, input logic rt_rd,
                               input logic wr_en, input logic [4:0] wr_addr,
                               input logic [1:0] lat, input logic hld,
                               input logic fl, input logic rn);
    id_rs      = rs;
    id_rt      = rt;
    id_rs_rd   = rs_rd;
    id_rt_rd   = rt_rd;
    id_wr_en   = wr_en;
    id_wr_addr = wr_addr;
    id_wr_lat  = lat;
    hold       = hld;
    flush      = fl;
    rst_n      = rn;
  endtask

  task automatic checkOutput(input exp_t e);
    compare("rs_sel", {30'd0, rs_sel}, {30'd0, e.rs_sel});
    compare("rt_sel", {30'd0, rt_sel}, {30'd0, e.rt_sel});
    compare("stall_id", {31'd0, stall_id}, {31'd0, e.stall});
`ifdef BYPASS_STALL_CNT_EN
    compare("stall_cnt", stall_cnt, e.cnt);
`endif
  endtask

  // One ID cycle: drive, predict, queue the prediction, then age the model.
  task automatic driveCycle(input logic [4:0] rs, input logic [4:0] rt,
                            input logic rs_rd, input logic rt_rd,
                            input logic wr_en, input logic [4:0] wr_addr,
                            input logic [1:0] lat, input logic hld,
                            input logic fl, input logic rn);
    exp_t e;
    logic rs_nr, rt_nr;
    @(negedge clk);
    applyStimulus(rs, rt, rs_rd, rt_rd, wr_en, wr_addr, lat, hld, fl, rn);
    #1;
    lookup(rs, rs_rd, e.rs_sel, rs_nr);
    lookup(rt, rt_rd, e.rt_sel, rt_nr);
    e.stall = (rs_nr | rt_nr) & ~fl;
    if (!rn) begin
      e.rs_sel = 2'b00;
      e.rt_sel = 2'b00;
      e.stall  = 1'b0;
    end
    e.cnt = model_cnt;
    exp_q.push_back(e);
    #2;
    obs_stall = stall_id;
    obs_rs    = rs_sel;
    @(posedge clk);
    if (!rn) begin
      inflight.delete();
      model_cnt = 0;
    end else begin
      if (e.stall && !hld) model_cnt++;
      if (fl) inflight.delete();
      else if (!hld) begin
        foreach (inflight[i]) inflight[i].age++;
        while (inflight.size() > 0 && inflight[inflight.size()-1].age > 2)
          void'(inflight.pop_back());
        if (wr_en && !e.stall)
          inflight.push_front('{addr: wr_addr, lat: (lat == 2'd3) ? 2 : int'(lat), age: 0});
      end
    end
  endtask

  // Monitor: the DUT presents an answer every cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int n;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    repeat (2) driveCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ALU result forwarded straight from EX to both operands.
    driveCycle(1, 2, 1, 1, 1, 3, 0, 0, 0, 1);
    driveCycle(3, 3, 1, 1, 1, 4, 0, 0, 0, 1);

    // Load-use: two bubbles, then the load data comes from MEM2.
    driveCycle(0, 0, 0, 0, 1, 5, 2, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      driveCycle(5, 0, 1, 1, 1, 6, 0, 0, 0, 1);
      if (obs_stall === 1'b1) n++;
      else break;
    end
    compare("load_use_stall_len", n, 2);
    compare("load_use_rs_sel", {30'd0, obs_rs}, 32'd3);

    // Load, independent instruction, dependent: one bubble.
    driveCycle(0, 0, 0, 0, 1, 10, 2, 0, 0, 1);
    driveCycle(0, 0, 0, 0, 1, 11, 0, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      driveCycle(10, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      if (obs_stall === 1'b1) n++;
      else break;
    end
    compare("load_gap_stall_len", n, 1);

    // Younger mflo shadows the older addu to the same register.
    driveCycle(0, 0, 0, 0, 1, 7, 0, 0, 0, 1);
    driveCycle(0, 0, 0, 0, 1, 7, 1, 0, 0, 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      driveCycle(7, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      if (obs_stall === 1'b1) n++;
      else break;
    end
    compare("mflo_stall_len", n, 1);
    compare("mflo_rs_sel", {30'd0, obs_rs}, 32'd2);

    // Writes to $0 are never forwarded.
    driveCycle(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    driveCycle(0, 0, 1, 1, 0, 0, 0, 0, 0, 1);

    // Load stall frozen by hold, then flushed away.
    driveCycle(0, 0, 0, 0, 1, 8, 2, 0, 0, 1);
    repeat (3) driveCycle(8, 8, 1, 1, 1, 9, 0, 1, 0, 1);
    driveCycle(8, 8, 1, 1, 1, 9, 0, 1, 1, 1);
    driveCycle(8, 8, 1, 1, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of a load stall.
    driveCycle(0, 0, 0, 0, 1, 9, 2, 0, 0, 1);
    driveCycle(9, 0, 1, 0, 1, 12, 0, 0, 0, 1);
    driveCycle(9, 0, 1, 0, 1, 12, 0, 1, 1, 0);
    driveCycle(9, 0, 1, 0, 1, 12, 0, 0, 0, 1);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      driveCycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 5),
                 1'($urandom_range(0, 99) >= 2));
    end

    repeat (2) @(negedge clk);
    #3;
    compare("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
